// File: rtl/controle_medidas_hcsr04_pkg.sv
// Shared definitions for the HC-SR04 measurement sequencer: state encodings,
// default 50 MHz timing constants and a counter-width helper.
package controle_medidas_hcsr04_pkg;

    typedef enum logic [3:0] {
        INICIAL = 4'd0,
        DISPARA = 4'd1,
        AGUARDA = 4'd2,
        ACUMULA = 4'd3,
        PUBLICA = 4'd4,
        FALHA   = 4'd5,
        ESPERA  = 4'd6
    } estado_t;

    localparam int PERIODO_PADRAO    = 5_000_000;
    localparam int TIMEOUT_PADRAO    = 2_000_000;
    localparam int LOG2_N_PADRAO     = 2;
    localparam int MAX_FALHAS_PADRAO = 3;
    localparam int LARGURA_MEDIDA    = 12;

    // Width that holds values 0..m-1, never less than one bit.
    function automatic int largura_contador(input int m);
        return (m > 1) ? $clog2(m) : 1;
    endfunction

endpackage

// File: rtl/controle_medidas_hcsr04_contador_m.sv
// Mod-M counter: zera clears, conta advances and wraps at M-1; fim flags the last value.
module contador_m
    import controle_medidas_hcsr04_pkg::*;
#(
    parameter int M = 100
) (
    input  logic clock,
    input  logic reset,
    input  logic zera,
    input  logic conta,
    output logic fim
);

    localparam int W = largura_contador(M);

    logic [W-1:0] valor_reg;

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            valor_reg <= '0;
        end else if (zera) begin
            valor_reg <= '0;
        end else if (conta) begin
            valor_reg <= (valor_reg == W'(M - 1)) ? '0 : valor_reg + W'(1);
        end
    end

    assign fim = (valor_reg == W'(M - 1));

endmodule

// File: rtl/controle_medidas_hcsr04.sv
// Periodic HC-SR04 measurement sequencer: fires medir, supervises each reading with a
// timeout, averages 2**LOG2_N valid samples and flags repeated missing echoes.
module controle_medidas_hcsr04
    import controle_medidas_hcsr04_pkg::*;
#(
    parameter int PERIODO    = PERIODO_PADRAO,
    parameter int TIMEOUT    = TIMEOUT_PADRAO,
    parameter int LOG2_N     = LOG2_N_PADRAO,
    parameter int MAX_FALHAS = MAX_FALHAS_PADRAO
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        ligar,
    input  logic        pronto_medida,
    input  logic [11:0] medida,
    output logic        medir,
    output logic [11:0] distancia,
    output logic        valida,
    output logic        erro,
    output logic [3:0]  db_estado
);

    localparam int SW = LARGURA_MEDIDA + LOG2_N;
    localparam int NW = LOG2_N + 1;
    localparam int FW = largura_contador(MAX_FALHAS + 1);

    estado_t       estado_reg;
    logic [SW-1:0] soma_reg;
    logic [11:0]   amostra_reg;
    logic [NW-1:0] n_amostras_reg;
    logic [FW-1:0] falhas_reg;
    logic          medir_reg;
    logic          valida_reg;
    logic          erro_reg;
    logic [11:0]   distancia_reg;

    logic [SW-1:0] soma_next;
    logic [SW-1:0] media_next;
    logic [NW-1:0] n_amostras_next;
    logic          fim_timeout;
    logic          fim_periodo;

    assign soma_next       = soma_reg + SW'(amostra_reg);
    assign media_next      = soma_next >> LOG2_N;
    assign n_amostras_next = n_amostras_reg + NW'(1);

    contador_m #(.M(TIMEOUT)) u_timeout (
        .clock (clock),
        .reset (reset),
        .zera  ((estado_reg != AGUARDA) || !ligar),
        .conta (estado_reg == AGUARDA),
        .fim   (fim_timeout)
    );

    contador_m #(.M(PERIODO)) u_periodo (
        .clock (clock),
        .reset (reset),
        .zera  ((estado_reg != ESPERA) || !ligar),
        .conta (estado_reg == ESPERA),
        .fim   (fim_periodo)
    );

    // medir and valida are set on the transition into DISPARA / PUBLICA, so each
    // is high for exactly the one cycle spent in that state.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            estado_reg     <= INICIAL;
            soma_reg       <= '0;
            amostra_reg    <= '0;
            n_amostras_reg <= '0;
            falhas_reg     <= '0;
            medir_reg      <= 1'b0;
            valida_reg     <= 1'b0;
            erro_reg       <= 1'b0;
            distancia_reg  <= '0;
        end else begin
            medir_reg  <= 1'b0;
            valida_reg <= 1'b0;
            if (!ligar) begin
                estado_reg     <= INICIAL;
                soma_reg       <= '0;
                n_amostras_reg <= '0;
                falhas_reg     <= '0;
            end else begin
                case (estado_reg)
                    INICIAL: begin
                        estado_reg <= DISPARA;
                        medir_reg  <= 1'b1;
                    end
                    DISPARA: begin
                        estado_reg <= AGUARDA;
                    end
                    AGUARDA: begin
                        // pronto has priority over a timeout ending in the same cycle
                        if (pronto_medida) begin
                            amostra_reg <= medida;
                            estado_reg  <= ACUMULA;
                        end else if (fim_timeout) begin
                            estado_reg <= FALHA;
                        end
                    end
                    ACUMULA: begin
                        soma_reg       <= soma_next;
                        n_amostras_reg <= n_amostras_next;
                        falhas_reg     <= '0;
                        if (n_amostras_next == NW'(1 << LOG2_N)) begin
                            distancia_reg <= media_next[11:0];
                            valida_reg    <= 1'b1;
                            erro_reg      <= 1'b0;
                            estado_reg    <= PUBLICA;
                        end else begin
                            estado_reg <= ESPERA;
                        end
                    end
                    PUBLICA: begin
                        soma_reg       <= '0;
                        n_amostras_reg <= '0;
                        estado_reg     <= ESPERA;
                    end
                    FALHA: begin
                        if (falhas_reg < FW'(MAX_FALHAS)) begin
                            falhas_reg <= falhas_reg + FW'(1);
                        end
                        if (falhas_reg >= FW'(MAX_FALHAS - 1)) begin
                            erro_reg <= 1'b1;
                        end
                        estado_reg <= ESPERA;
                    end
                    ESPERA: begin
                        if (fim_periodo) begin
                            estado_reg <= DISPARA;
                            medir_reg  <= 1'b1;
                        end
                    end
                    default: begin
                        estado_reg <= INICIAL;
                    end
                endcase
            end
        end
    end

    assign medir     = medir_reg;
    assign valida    = valida_reg;
    assign erro      = erro_reg;
    assign distancia = distancia_reg;
    assign db_estado = estado_reg;

endmodule

// File: tb/tb_controle_medidas_hcsr04.sv
// Self-checking bench: a sensor model answers medir pulses from a response queue,
// and expected averages wait in a scoreboard until valida pops them.
module tb_controle_medidas_hcsr04;

    logic        clock = 1'b0;
    logic        reset;
    logic        ligar;
    logic        pronto_medida;
    logic [11:0] medida;
    logic        medir;
    logic [11:0] distancia;
    logic        valida;
    logic        erro;
    logic [3:0]  db_estado;

    int n_comp = 0;
    int n_err  = 0;

    int resp_q[$];   // -1 = no echo for that medir
    int sb_q[$];

    int cyc = 0, medir_cnt = 0, valida_cnt = 0, acc_cnt = 0;
    int last_medir = 0, last_delta = 0;
    int wide_medir = 0, wide_valida = 0;
    bit medir_prev = 0, valida_prev = 0, erro_seen = 0;

    controle_medidas_hcsr04 #(
        .PERIODO(100), .TIMEOUT(50), .LOG2_N(2), .MAX_FALHAS(3)
    ) dut (
        .clock(clock), .reset(reset), .ligar(ligar),
        .pronto_medida(pronto_medida), .medida(medida),
        .medir(medir), .distancia(distancia), .valida(valida),
        .erro(erro), .db_estado(db_estado)
    );

    always #5 clock = ~clock;

    task automatic verificar(input string tag, input int obs, input int esp);
        n_comp++;
        if (obs !== esp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d", tag, obs, esp);
        end
    endtask

    // sensor model
    initial begin
        int v;
        bit abortar;
        pronto_medida = 1'b0;
        medida = '0;
        forever begin
            @(negedge clock);
            if (!reset && medir && resp_q.size() > 0) begin
                v = resp_q.pop_front();
                if (v >= 0) begin
                    abortar = 0;
                    for (int i = 0; i < 19; i++) begin
                        @(negedge clock);
                        if (reset) abortar = 1;
                    end
                    if (!abortar && !reset) begin
                        pronto_medida = 1'b1;
                        medida = 12'(v);
                        @(negedge clock);
                        pronto_medida = 1'b0;
                    end
                end
            end
        end
    end

    // output monitor and scoreboard
    initial begin
        int esp;
        forever begin
            @(negedge clock);
            cyc++;
            if (medir) begin
                medir_cnt++;
                if (medir_prev) wide_medir++;
                last_delta = cyc - last_medir;
                last_medir = cyc;
            end
            if (valida && !reset) begin
                valida_cnt++;
                if (valida_prev) wide_valida++;
                if (sb_q.size() == 0) begin
                    verificar("valida_inesperado", 1, 0);
                end else begin
                    esp = sb_q.pop_front();
                    $display("valida #%0d: distancia=%0d esperado=%0d", valida_cnt, distancia, esp);
                    verificar("distancia", int'(distancia), esp);
                end
            end
            if (db_estado == 4'd3) acc_cnt++;
            if (erro) erro_seen = 1;
            medir_prev  = medir;
            valida_prev = valida;
        end
    end

    task automatic esperar_valida(input int alvo, input int limite);
        int k = 0;
        while (valida_cnt < alvo && k < limite) begin
            @(negedge clock); #1; k++;
        end
        verificar("espera_valida", int'(valida_cnt >= alvo), 1);
    endtask

    task automatic esperar_estado(input int e, input int limite);
        int k = 0;
        do begin
            @(posedge clock); #1; k++;
        end while (int'(db_estado) != e && k < limite);
        verificar("espera_estado", int'(db_estado), e);
    endtask

    task automatic checar_zerado(input string tag);
        verificar({tag, "_estado"}, int'(db_estado), 0);
        verificar({tag, "_medir"}, int'(medir), 0);
        verificar({tag, "_valida"}, int'(valida), 0);
        verificar({tag, "_erro"}, int'(erro), 0);
        verificar({tag, "_distancia"}, int'(distancia), 0);
    endtask

    initial begin
        int m0, v0, a0, k;
        reset = 1'b1;
        ligar = 1'b0;
        repeat (3) @(negedge clock);
        checar_zerado("rst");
        reset = 1'b0;

        // 1: four answered samples average to 101
        m0 = medir_cnt; v0 = valida_cnt;
        resp_q = '{100, 102, 98, 104};
        sb_q.push_back(101);
        ligar = 1'b1;
        esperar_valida(v0 + 1, 1000);
        verificar("t1_medir_cnt", medir_cnt - m0, 4);

        // 2: no echoes -> erro after the third timeout
        ligar = 1'b0;
        @(negedge clock); reset = 1'b1;
        @(negedge clock); reset = 1'b0;
        verificar("t2_dist_rst", int'(distancia), 0);
        m0 = medir_cnt; v0 = valida_cnt;
        ligar = 1'b1;
        k = 0;
        while (medir_cnt - m0 < 3 && k < 1000) begin @(negedge clock); #1; k++; end
        verificar("t2_erro_apos_2", int'(erro), 0);
        k = 0;
        while (!erro && k < 400) begin @(negedge clock); #1; k++; end
        verificar("t2_erro", int'(erro), 1);
        verificar("t2_medir_cnt", medir_cnt - m0, 3);
        verificar("t2_espacamento", last_delta, 152);
        verificar("t2_sem_valida", valida_cnt - v0, 0);
        verificar("t2_distancia", int'(distancia), 0);

        // 3: recovery clears erro
        v0 = valida_cnt;
        resp_q = '{200, 200, 200, 200};
        sb_q.push_back(200);
        esperar_valida(v0 + 1, 1000);
        verificar("t3_erro", int'(erro), 0);

        // 4: two timeouts then a success, repeated; erro must never rise
        v0 = valida_cnt;
        erro_seen = 0;
        resp_q = '{-1, -1, 40, -1, -1, 44, -1, -1, 48, -1, -1, 52};
        sb_q.push_back(46);
        esperar_valida(v0 + 1, 3000);
        verificar("t4_erro_nunca", int'(erro_seen), 0);

        // 5: drop ligar after two samples; partial sum must be discarded
        a0 = acc_cnt; v0 = valida_cnt;
        resp_q = '{300, 300};
        k = 0;
        while (acc_cnt - a0 < 2 && k < 600) begin @(negedge clock); #1; k++; end
        verificar("t5_duas_amostras", acc_cnt - a0, 2);
        ligar = 1'b0;
        repeat (2) @(negedge clock);
        verificar("t5_inicial", int'(db_estado), 0);
        verificar("t5_dist_mantida", int'(distancia), 46);
        resp_q = '{50, 50, 50, 50};
        sb_q.push_back(50);
        ligar = 1'b1;
        esperar_valida(v0 + 1, 1000);

        // 6: async reset in AGUARDA and in PUBLICA, then clean restart
        esperar_estado(2, 400);
        #2 reset = 1'b1;
        #1 checar_zerado("t6_aguarda");
        repeat (3) @(negedge clock);
        reset = 1'b0;
        resp_q = '{10, 10, 10, 10};
        esperar_estado(4, 1000);
        reset = 1'b1;
        #1 checar_zerado("t6_publica");
        repeat (3) @(negedge clock);
        resp_q.delete();
        v0 = valida_cnt;
        resp_q = '{7, 8, 9, 10};
        sb_q.push_back(8);
        reset = 1'b0;
        esperar_valida(v0 + 1, 1000);

        ligar = 1'b0;
        repeat (5) @(negedge clock);
        verificar("sb_vazio", sb_q.size(), 0);
        verificar("medir_largura", wide_medir, 0);
        verificar("valida_largura", wide_valida, 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_comp, n_err);
        $finish;
    end

endmodule
